// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: issue, writeback-requester and regfile write-port signals of the writeback controller
interface regfile_wb_ctrl_if #(parameter int XLEN = 64, parameter int NREG = 32, parameter int AW = 5);
   logic            iss_en;
   logic [AW-1:0]   iss_rd;
   logic            iss_rs1_en;
   logic [AW-1:0]   iss_rs1;
   logic            iss_rs2_en;
   logic [AW-1:0]   iss_rs2;
   logic            stall;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [NREG-1:0] busy;
   logic [AW:0]     n_pending;
   logic            err_wb;
   modport slave (
      input  iss_en, iss_rd, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output stall, alu_ready, lsu_ready, wr_en, wr_addr, wr_data, busy, n_pending, err_wb
   );
   modport master (
      output iss_en, iss_rd, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  stall, alu_ready, lsu_ready, wr_en, wr_addr, wr_data, busy, n_pending, err_wb
   );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin ALU/LSU writeback arbitration, busy scoreboard and RAW/WAW issue stall
module regfile_wb_ctrl #(parameter int XLEN = 64, parameter int NREG = 32, parameter int AW = 5) (
   input logic               clk,
   input logic               rst,
   regfile_wb_ctrl_if.slave  bus
);
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     n_pend;
   logic            last_lsu, err_q, alu_gnt, lsu_gnt, xfer, accept;
   logic [AW-1:0]   g_rd;
   logic [XLEN-1:0] g_data;
   // on collision the requester that did not win last time gets the port
   assign alu_gnt = ~rst & bus.alu_valid & (~bus.lsu_valid | last_lsu);
   assign lsu_gnt = ~rst & bus.lsu_valid & ~alu_gnt;
   assign xfer    = alu_gnt | lsu_gnt;
   assign g_rd    = alu_gnt ? bus.alu_rd : bus.lsu_rd;
   assign g_data  = alu_gnt ? bus.alu_data : bus.lsu_data;
   assign bus.alu_ready = alu_gnt;
   assign bus.lsu_ready = lsu_gnt;
   assign bus.wr_en     = xfer & (g_rd != '0);
   assign bus.wr_addr   = bus.wr_en ? g_rd : '0;
   assign bus.wr_data   = bus.wr_en ? g_data : '0;
   // registered busy only: a same-cycle writeback does not release the stall
   assign bus.stall = ~rst & bus.iss_en & ((bus.iss_rs1_en & busy_q[bus.iss_rs1])
                                         | (bus.iss_rs2_en & busy_q[bus.iss_rs2])
                                         | busy_q[bus.iss_rd]);
   assign accept        = ~rst & bus.iss_en & ~bus.stall;
   assign bus.busy      = busy_q;
   assign bus.n_pending = n_pend;
   assign bus.err_wb    = err_q;
   always_comb begin
      busy_d = busy_q;
      if (bus.wr_en) busy_d[g_rd] = 1'b0;
      if (accept) busy_d[bus.iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_comb begin
      n_pend = '0;
      for (int i = 0; i < NREG; i++) n_pend = n_pend + (AW+1)'(busy_q[i]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         last_lsu <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (xfer) last_lsu <= lsu_gnt;
         if (bus.wr_en && !busy_q[g_rd]) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed stimulus with a write-port scoreboard queue and a negedge monitor
module tb_regfile_wb_ctrl;
   typedef struct packed {
      logic        a;
      logic        l;
      logic        w;
      logic [4:0]  addr;
      logic [63:0] d;
   } wb_t;
   logic clk = 0;
   logic rst = 1;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   done  = 0;
   wb_t  exp_q[$];
   regfile_wb_ctrl_if bus ();
   regfile_wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic a, input logic l, input logic w, input logic [4:0] addr, input logic [63:0] d);
      exp_q.push_back('{a: a, l: l, w: w, addr: addr, d: d});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.iss_en = 0; bus.iss_rd = 0; bus.iss_rs1_en = 0; bus.iss_rs1 = 0;
      bus.iss_rs2_en = 0; bus.iss_rs2 = 0;
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      bus.iss_en = 1; bus.iss_rd = rd;
      tick();
   endtask

   task automatic alu(input logic [4:0] rd, input logic [63:0] d);
      bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_data = d;
   endtask

   task automatic lsu(input logic [4:0] rd, input logic [63:0] d);
      bus.lsu_valid = 1; bus.lsu_rd = rd; bus.lsu_data = d;
   endtask

   // every cycle: either the DUT presents a grant/write or an expected entry is due
   always @(negedge clk) begin
      wb_t act, exp;
      if (!done) begin
         act = '{a: bus.alu_ready, l: bus.lsu_ready, w: bus.wr_en, addr: bus.wr_addr, d: bus.wr_data};
         exp = exp_q.size() > 0 ? exp_q.pop_front() : '0;
         if (act != '0 || exp != '0) chk("wb_port", act, exp);
      end
   end

   initial begin
      idle();
      alu(0, 64'h5);
      lsu(3, 64'h6);
      tick();
      @(negedge clk);
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      tick();
      rst = 0;
      idle();
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_npend", bus.n_pending, 0);
      chk("reset_err", bus.err_wb, 0);
      // issue x5 then ALU writeback
      issue(5);
      idle();
      @(negedge clk);
      chk("t1_busy5_set", bus.busy[5], 1);
      chk("t1_npend1", bus.n_pending, 1);
      alu(5, 64'h1234);
      push(1, 0, 1, 5, 64'h1234);
      tick();
      idle();
      @(negedge clk);
      chk("t1_busy5_clr", bus.busy[5], 0);
      chk("t1_npend0", bus.n_pending, 0);
      // LSU rd=0 so that last_grant is LSU before the collision run
      lsu(0, 64'hAB);
      push(0, 1, 0, 0, 0);
      tick();
      issue(10); issue(11); issue(12); issue(13);
      idle();
      @(negedge clk);
      chk("t2_busy", bus.busy, 32'h0000_3C00);
      alu(10, 64'hA0); lsu(12, 64'hB0); push(1, 0, 1, 10, 64'hA0); tick();
      alu(11, 64'hA1);                  push(0, 1, 1, 12, 64'hB0); tick();
      lsu(13, 64'hB1);                  push(1, 0, 1, 11, 64'hA1); tick();
      alu(0, 64'hA2);                   push(0, 1, 1, 13, 64'hB1); tick();
      bus.lsu_valid = 0;                push(1, 0, 0, 0, 0);       tick();
      idle();
      @(negedge clk);
      chk("t2_busy_clr", bus.busy, 0);
      chk("t2_err", bus.err_wb, 0);
      // RAW on x7 with a same-cycle LSU writeback
      issue(7);
      idle();
      bus.iss_en = 1; bus.iss_rd = 8; bus.iss_rs1_en = 1; bus.iss_rs1 = 7;
      lsu(7, 64'h77);
      push(0, 1, 1, 7, 64'h77);
      @(negedge clk);
      chk("t3_stall_same", bus.stall, 1);
      tick();
      bus.lsu_valid = 0;
      @(negedge clk);
      chk("t3_stall_next", bus.stall, 0);
      tick();
      idle();
      @(negedge clk);
      chk("t3_busy", bus.busy, 32'h0000_0100);
      alu(8, 64'h88);
      push(1, 0, 1, 8, 64'h88);
      tick();
      // rd=0 writeback: handshake only
      alu(0, 64'hFFFF);
      push(1, 0, 0, 0, 0);
      tick();
      idle();
      @(negedge clk);
      chk("t4_busy", bus.busy, 0);
      chk("t4_err", bus.err_wb, 0);
      // WAW on x3 with a same-cycle writeback: stalled, then accepted next cycle
      issue(3);
      idle();
      bus.iss_en = 1; bus.iss_rd = 3;
      alu(3, 64'h33);
      push(1, 0, 1, 3, 64'h33);
      @(negedge clk);
      chk("t5_stall_waw", bus.stall, 1);
      tick();
      bus.alu_valid = 0;
      @(negedge clk);
      chk("t5_busy3_clr", bus.busy[3], 0);
      chk("t5_stall_rel", bus.stall, 0);
      tick();
      idle();
      @(negedge clk);
      chk("t5_busy3_set", bus.busy[3], 1);
      alu(9, 64'h99);
      push(1, 0, 1, 9, 64'h99);
      tick();
      idle();
      @(negedge clk);
      chk("t5_err_set", bus.err_wb, 1);
      alu(3, 64'h3);
      push(1, 0, 1, 3, 64'h3);
      tick();
      idle();
      @(negedge clk);
      chk("t5_err_sticky", bus.err_wb, 1);
      // reset mid-traffic with x4..x7 pending; last grant is ALU here
      issue(4); issue(5); issue(6); issue(7);
      idle();
      @(negedge clk);
      chk("t6_busy", bus.busy, 32'h0000_00F0);
      chk("t6_npend", bus.n_pending, 4);
      rst = 1;
      alu(0, 64'h1); lsu(0, 64'h2);
      bus.iss_en = 1; bus.iss_rd = 9; bus.iss_rs1_en = 1; bus.iss_rs1 = 4;
      @(negedge clk);
      chk("t6_rst_lsu_ready", bus.lsu_ready, 0);
      chk("t6_rst_stall", bus.stall, 0);
      tick();
      rst = 0;
      bus.iss_en = 0;
      push(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t6_busy_clr", bus.busy, 0);
      chk("t6_err_clr", bus.err_wb, 0);
      tick();
      idle();
      @(negedge clk);
      #1;
      done = 1;
      chk("queue_drained", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
